// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and complex-word packing for the FFT input path.
package fft_pkg;

   localparam int FFT_WORD_W = 32;
   localparam int RE_LSB     = 0;
   localparam int IM_LSB     = 16;
   localparam int COEF_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      PAD    = 2'd2
   } fsm_state_t;

   function automatic logic [FFT_WORD_W-1:0] pack_cplx(input logic [15:0] re,
                                                       input logic [15:0] im);
      logic [FFT_WORD_W-1:0] w;
      w = '0;
      w[RE_LSB +: 16] = re;
      w[IM_LSB +: 16] = im;
      return w;
   endfunction

endpackage

// File: rtl/fft_window_rom.sv
// Hann window coefficient ROM (unsigned Q1.15), synchronous 1-cycle read with enable.
module fft_window_rom
   import fft_pkg::*;
#(
   parameter int FRAME_LEN = 1024,
   parameter int AW        = 10
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [AW-1:0]     i_addr,
   output logic [COEF_W-1:0] o_coef
);

   function automatic logic [COEF_W-1:0] hann(input int unsigned i);
      real x;
      x = 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * real'(i) / real'(FRAME_LEN)));
      return COEF_W'($rtoi(x * 32767.0 + 0.5));
   endfunction

   logic [COEF_W-1:0] rom [FRAME_LEN];

   for (genvar g = 0; g < FRAME_LEN; g++) begin : g_rom
      localparam logic [COEF_W-1:0] C = hann(g);
      assign rom[g] = C;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     o_coef <= '0;
      else if (i_en) o_coef <= rom[i_addr];
   end

endmodule

// File: rtl/fft_frame_feeder.sv
// Packs real samples into complex words, frames them with last/flush padding, 2-entry skid output.
// Optional Hann windowing stage compiled in with `define WINDOW_EN.
module fft_frame_feeder
   import fft_pkg::*;
#(
   parameter int FRAME_LEN = 1024,
   parameter int SAMPLE_W  = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [SAMPLE_W-1:0] i_sample,
   input  logic                i_sample_valid,
   output logic                o_sample_ready,
   input  logic                i_flush,
   output logic [31:0]         o_data,
   output logic                o_data_valid,
   output logic                o_data_last,
   input  logic                i_data_ready,
   output logic [15:0]         o_frame_cnt,
   output logic                o_busy
);

   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   fsm_state_t              state, state_nxt;
   logic [IDX_W-1:0]        index;
   logic                    accept, pad_issue, issue, issue_last, flush_eff;
   logic signed [SAMPLE_W-1:0] sample_s;
   logic signed [15:0]      issue_re;

   logic [FFT_WORD_W-1:0]   buf_data [2];
   logic [1:0]              buf_last;
   logic                    wr_ptr, rd_ptr;
   logic [1:0]              cnt, cnt_nxt;
   logic                    buf_wr, buf_wr_last, rd, ready_nxt;
   logic [FFT_WORD_W-1:0]   buf_wr_data;

   assign sample_s   = i_sample;
   assign accept     = i_sample_valid && o_sample_ready;
   assign issue      = accept || pad_issue;
   assign issue_last = (index == LAST_IDX);
   // pad words enter the datapath as a zero sample so both build variants share one path
   assign issue_re   = accept ? 16'(sample_s) : '0;
   assign flush_eff  = i_flush && (state != PAD) && (accept || state == STREAM)
                       && !(accept && issue_last);

   assign rd           = o_data_valid && i_data_ready;
   assign o_data_valid = (cnt != 2'd0);
   assign o_data       = buf_data[rd_ptr];
   assign o_data_last  = buf_last[rd_ptr];
   assign o_busy       = (index != '0) || (state == PAD);
   assign cnt_nxt      = cnt + 2'(buf_wr) - 2'(rd);

`ifdef WINDOW_EN
   logic                    pv, pv_nxt, p_last, stage_move;
   logic signed [15:0]      p_re;
   logic [COEF_W-1:0]       coef;
   logic signed [32:0]      prod;
   logic signed [33:0]      rnd;

   fft_window_rom #(.FRAME_LEN(FRAME_LEN), .AW(IDX_W)) u_rom (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (issue),
      .i_addr (index),
      .o_coef (coef)
   );

   assign stage_move  = pv && (cnt != 2'd2);
   assign pad_issue   = (state == PAD) && (!pv || stage_move);
   assign prod        = p_re * $signed({1'b0, coef});
   assign rnd         = {prod[32], prod} + 34'sd16384;
   assign buf_wr      = stage_move;
   assign buf_wr_last = p_last;
   assign buf_wr_data = pack_cplx(rnd[30:15], '0);

   always_comb begin
      pv_nxt = pv;
      if (issue)           pv_nxt = 1'b1;
      else if (stage_move) pv_nxt = 1'b0;
   end

   // the staged word counts as a third slot, so streaming keeps ready high
   assign ready_nxt = (state_nxt != PAD) && ((3'(cnt_nxt) + 3'(pv_nxt)) < 3'd3);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pv     <= 1'b0;
         p_re   <= '0;
         p_last <= 1'b0;
      end else begin
         pv <= pv_nxt;
         if (issue) begin
            p_re   <= issue_re;
            p_last <= issue_last;
         end
      end
   end
`else
   assign pad_issue   = (state == PAD) && (cnt != 2'd2);
   assign buf_wr      = issue;
   assign buf_wr_last = issue_last;
   assign buf_wr_data = pack_cplx(issue_re, '0);
   assign ready_nxt   = (state_nxt != PAD) && (cnt_nxt != 2'd2);
`endif

   always_comb begin
      state_nxt = state;
      if (issue && issue_last) state_nxt = IDLE;
      else if (flush_eff)      state_nxt = PAD;
      else if (accept)         state_nxt = STREAM;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= IDLE;
         index          <= '0;
         o_sample_ready <= 1'b0;
         o_frame_cnt    <= '0;
      end else begin
         state          <= state_nxt;
         o_sample_ready <= ready_nxt;
         if (issue)                 index       <= index + IDX_W'(1);
         if (buf_wr && buf_wr_last) o_frame_cnt <= o_frame_cnt + 16'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < 2; i++) buf_data[i] <= '0;
         buf_last <= '0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         cnt      <= '0;
      end else begin
         if (buf_wr) begin
            buf_data[wr_ptr] <= buf_wr_data;
            buf_last[wr_ptr] <= buf_wr_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (rd) rd_ptr <= ~rd_ptr;
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Scoreboard bench for fft_frame_feeder: directed scenarios plus randomized traffic vs a frame model.
module tb_fft_frame_feeder;

   localparam int FL = 8;
   localparam int SW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic [SW-1:0] i_sample;
   logic          i_sample_valid;
   logic          o_sample_ready;
   logic          i_flush;
   logic [31:0]   o_data;
   logic          o_data_valid;
   logic          o_data_last;
   logic          i_data_ready;
   logic [15:0]   o_frame_cnt;
   logic          o_busy;

   always #5 i_clk = ~i_clk;

   fft_frame_feeder #(.FRAME_LEN(FL), .SAMPLE_W(SW)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .i_flush        (i_flush),
      .o_data         (o_data),
      .o_data_valid   (o_data_valid),
      .o_data_last    (o_data_last),
      .i_data_ready   (i_data_ready),
      .o_frame_cnt    (o_frame_cnt),
      .o_busy         (o_busy)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } exp_t;

   exp_t exp_q[$];
   time  pop_t[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   pos      = 0;
   int   frames_exp = 0;
   logic rdy_rand = 1'b0;

   function automatic void check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int hann_c(input int i);
      real x;
      x = 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * real'(i) / real'(FL)));
      return $rtoi(x * 32767.0 + 0.5);
   endfunction

   function automatic logic [15:0] model_re(input logic [SW-1:0] s, input int p);
      longint sv;
      sv = longint'(signed'(s));
`ifdef WINDOW_EN
      return 16'((sv * longint'(hann_c(p)) + 64'sd16384) >>> 15);
`else
      if (p < 0) sv = 0;
      return 16'(sv);
`endif
   endfunction

   function automatic void push_word(input logic [15:0] re);
      exp_t e;
      e.data = {16'h0000, re};
      e.last = (pos == FL - 1);
      exp_q.push_back(e);
      if (e.last) frames_exp++;
      pos = (pos + 1) % FL;
   endfunction

   function automatic void model_accept(input logic [SW-1:0] s);
      push_word(model_re(s, pos));
   endfunction

   function automatic void model_flush();
      while (pos != 0) push_word(16'h0000);
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      pos = 0;
      frames_exp = 0;
   endfunction

   // monitor: pops expected words on every output handshake and checks hold stability
   logic        hold_v = 1'b0;
   logic [31:0] hold_d;
   logic        hold_l;

   always @(negedge i_clk) begin
      if (i_rst) begin
         hold_v <= 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", o_data_valid, 1);
            check("hold_data", o_data, hold_d);
            check("hold_last", o_data_last, hold_l);
         end
         if (o_data_valid && i_data_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got 0x%0h expected none at %0t", o_data, $time);
            end else begin
               check("word_data", o_data, exp_q[0].data);
               check("word_last", o_data_last, exp_q[0].last);
               void'(exp_q.pop_front());
               pop_t.push_back($time);
            end
         end
         hold_v <= o_data_valid && !i_data_ready;
         hold_d <= o_data;
         hold_l <= o_data_last;
      end
   end

   task automatic cyc(input logic v, input logic [SW-1:0] s, input logic f, output logic acc);
      i_sample_valid = v;
      i_sample       = s;
      i_flush        = f;
      if (rdy_rand) i_data_ready = ($urandom_range(0, 3) != 0);
      acc = v && o_sample_ready && !i_rst;
      if (acc) model_accept(s);
      if (f) model_flush();
      @(posedge i_clk);
      #1;
      i_sample_valid = 1'b0;
      i_flush        = 1'b0;
   endtask

   task automatic send(input logic [SW-1:0] s);
      logic acc;
      int   n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         cyc(1'b1, s, 1'b0, acc);
         n++;
      end
      check("send_accepted", acc, 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge i_clk);
         #1;
         n++;
      end
      repeat (3) @(posedge i_clk);
      #1;
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc;
      int   acc_cnt;
      logic [SW-1:0] s;

      i_rst          = 1'b1;
      i_sample       = '0;
      i_sample_valid = 1'b0;
      i_flush        = 1'b0;
      i_data_ready   = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_valid", o_data_valid, 0);
      check("rst_data", o_data, 0);
      check("rst_last", o_data_last, 0);
      check("rst_frame_cnt", o_frame_cnt, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_sample_ready, 0);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      check("ready_after_reset", o_sample_ready, 1);

      // two back-to-back frames of 1..16
      pop_t.delete();
      for (int i = 1; i <= 16; i++) send(SW'(i));
      drain();
      check("stream_frame_cnt", o_frame_cnt, 2);
      check("stream_words", pop_t.size(), 16);
      if (pop_t.size() == 16) check("stream_no_bubbles", longint'(pop_t[15] - pop_t[0]), 150);

      // most negative sample, then flush of a 3-word partial frame
      send(16'h8000);
      send(16'h1234);
      send(16'hFFFF);
      cyc(1'b0, '0, 1'b1, acc);
      check("pad_ready_low", o_sample_ready, 0);
      check("pad_busy", o_busy, 1);
      drain();
      check("pad_done_busy", o_busy, 0);
      check("pad_done_ready", o_sample_ready, 1);
      check("pad_frame_cnt", o_frame_cnt, frames_exp);

      // downstream stall: buffer fills, ready drops, nothing lost after release
      send(16'h0042);
      drain();
      i_data_ready = 1'b0;
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, SW'($urandom), 1'b0, acc);
         if (acc) acc_cnt++;
      end
`ifdef WINDOW_EN
      check("stall_accepted", acc_cnt, 3);
`else
      check("stall_accepted", acc_cnt, 2);
`endif
      check("stall_ready_low", o_sample_ready, 0);
      i_data_ready = 1'b1;
      drain();
      cyc(1'b0, '0, 1'b1, acc);
      drain();

      // reset mid-frame discards the partial frame
      send(16'h0011);
      send(16'h0022);
      send(16'h0033);
      i_rst = 1'b1;
      model_reset();
      @(posedge i_clk);
      #1;
      check("midrst_valid", o_data_valid, 0);
      check("midrst_last", o_data_last, 0);
      check("midrst_data", o_data, 0);
      check("midrst_frame_cnt", o_frame_cnt, 0);
      check("midrst_busy", o_busy, 0);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
      for (int i = 0; i < FL; i++) send(SW'(16'h0100 + i));
      drain();
      check("midrst_frame_after", o_frame_cnt, 1);

      // randomized traffic with random backpressure and occasional flush
      rdy_rand = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 7))
            0:       s = 16'h8000;
            1:       s = 16'h7FFF;
            default: s = SW'($urandom);
         endcase
         cyc(($urandom_range(0, 3) != 0), s, ($urandom_range(0, 29) == 0), acc);
      end
      rdy_rand = 1'b0;
      i_data_ready = 1'b1;
      cyc(1'b0, '0, 1'b1, acc);
      drain();
      check("rand_frame_cnt", o_frame_cnt, frames_exp % 65536);
      check("rand_idle_busy", o_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
